run_monitor: RTL and testbench

RUN_MONITOR -- requirements
Module: run_monitor

---
 rtl/run_monitor_pkg.sv | 20 ++
 rtl/run_monitor_sat_counter.sv | 28 ++
 rtl/run_monitor.sv | 155 +++++++++++++++
 tb/tb_run_monitor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/run_monitor_pkg.sv
// Shared definitions for the run monitor: FSM state encoding and helpers.
package run_monitor_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_RST_HOLD = 3'd1,
      ST_RUN      = 3'd2,
      ST_PASS     = 3'd3,
      ST_FAIL     = 3'd4,
      ST_TIMEOUT  = 3'd5
   } state_t;

   // True for the three end-of-run states, which all behave alike.
   function automatic logic isTerminal(input state_t s);
      return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
   endfunction

endpackage

// File: rtl/run_monitor_sat_counter.sv
// Up-counter with synchronous clear, count enable and optional saturation.
// With saturate low the counter wraps at its maximum value.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic         saturate,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX_VAL = '1;

   logic atMax;
   assign atMax = (count == MAX_VAL);

   // Clear wins over enable; a saturating counter sticks at all-ones.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && !(saturate && atMax)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/run_monitor.sv
// Supervises one test run of a core: holds the core in reset, releases it,
// watches stores for the pass/fail signature and applies a cycle budget.
// The state register is the observable FSM state for checkers (state).
module run_monitor
   import run_monitor_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int CNT_W      = 16,
   parameter int RST_CYCLES = 2,
   parameter int MAX_CYCLES = 16,
   parameter int PASS_ADDR  = 100,
   parameter int PASS_DATA  = 25
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mem_write,
   input  logic [XLEN-1:0]  data_addr,
   input  logic [XLEN-1:0]  write_data,
   input  logic [XLEN-1:0]  pc,
   output logic             core_reset,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] store_count,
   output logic [XLEN-1:0]  final_pc
);

   // Enough bits to hold RST_CYCLES-1, at least one bit.
   localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   state_t            state;
   logic [HOLD_W-1:0] holdCnt;

   logic enterHold;
   logic inRun;
   logic runStore;
   logic sigAddr;
   logic passHit;
   logic failHit;
   logic lastCycle;
   logic holdDone;

   // A new run may only be requested from IDLE or from a finished run.
   assign enterHold = start && ((state == ST_IDLE) || isTerminal(state));
   assign inRun     = (state == ST_RUN);
   assign runStore  = inRun && mem_write;
   assign sigAddr   = (data_addr == XLEN'(PASS_ADDR));
   assign passHit   = runStore && sigAddr && (write_data == XLEN'(PASS_DATA));
   assign failHit   = runStore && sigAddr && (write_data != XLEN'(PASS_DATA));
   assign lastCycle = inRun && (cycle_count == CNT_W'(MAX_CYCLES - 1));
   assign holdDone  = (state == ST_RST_HOLD) && (holdCnt == HOLD_W'(RST_CYCLES - 1));

   // Length of the core reset pulse; restarted whenever a run is requested.
   sat_counter #(.W(HOLD_W)) uHoldCnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (enterHold),
      .enable   (state == ST_RST_HOLD),
      .saturate (1'b1),
      .count    (holdCnt)
   );

   // RUN cycles elapsed; the terminating cycle is counted too.
   sat_counter #(.W(CNT_W)) uCycleCnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (enterHold),
      .enable   (inRun),
      .saturate (1'b1),
      .count    (cycle_count)
   );

   // Stores issued by the core while running, sticking at all-ones.
   sat_counter #(.W(CNT_W)) uStoreCnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (enterHold),
      .enable   (runStore),
      .saturate (1'b1),
      .count    (store_count)
   );

   // Run FSM with registered status outputs; pass beats fail beats timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         core_reset <= 1'b1;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         timeout    <= 1'b0;
         final_pc   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               core_reset <= 1'b1;
               if (start) begin
                  state    <= ST_RST_HOLD;
                  final_pc <= '0;
               end
            end
            ST_RST_HOLD: begin
               if (holdDone) begin
                  state      <= ST_RUN;
                  core_reset <= 1'b0;
               end
            end
            ST_RUN: begin
               if (passHit) begin
                  state      <= ST_PASS;
                  pass       <= 1'b1;
                  done       <= 1'b1;
                  core_reset <= 1'b1;
                  final_pc   <= pc;
               end else if (failHit) begin
                  state      <= ST_FAIL;
                  fail       <= 1'b1;
                  done       <= 1'b1;
                  core_reset <= 1'b1;
                  final_pc   <= pc;
               end else if (lastCycle) begin
                  state      <= ST_TIMEOUT;
                  timeout    <= 1'b1;
                  done       <= 1'b1;
                  core_reset <= 1'b1;
                  final_pc   <= pc;
               end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: begin
               core_reset <= 1'b1;
               if (start) begin
                  state    <= ST_RST_HOLD;
                  done     <= 1'b0;
                  pass     <= 1'b0;
                  fail     <= 1'b0;
                  timeout  <= 1'b0;
                  final_pc <= '0;
               end
            end
            default: begin
               state      <= ST_IDLE;
               core_reset <= 1'b1;
               done       <= 1'b0;
               pass       <= 1'b0;
               fail       <= 1'b0;
               timeout    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: instance A uses default parameters,
// instance B a 2-bit counter width with a 3-cycle budget. Both share inputs.
module tb_run_monitor;

   logic        clk;
   logic        reset;
   logic        start;
   logic        mem_write;
   logic [31:0] data_addr;
   logic [31:0] write_data;
   logic [31:0] pc;

   logic        aCoreReset, aDone, aPass, aFail, aTimeout;
   logic [15:0] aCycleCount, aStoreCount;
   logic [31:0] aFinalPc;

   logic        bCoreReset, bDone, bPass, bFail, bTimeout;
   logic [1:0]  bCycleCount, bStoreCount;
   logic [31:0] bFinalPc;

   int total = 0;
   int bad   = 0;

   run_monitor dutA (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mem_write   (mem_write),
      .data_addr   (data_addr),
      .write_data  (write_data),
      .pc          (pc),
      .core_reset  (aCoreReset),
      .done        (aDone),
      .pass        (aPass),
      .fail        (aFail),
      .timeout     (aTimeout),
      .cycle_count (aCycleCount),
      .store_count (aStoreCount),
      .final_pc    (aFinalPc)
   );

   run_monitor #(.CNT_W(2), .MAX_CYCLES(3)) dutB (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mem_write   (mem_write),
      .data_addr   (data_addr),
      .write_data  (write_data),
      .pc          (pc),
      .core_reset  (bCoreReset),
      .done        (bDone),
      .pass        (bPass),
      .fail        (bFail),
      .timeout     (bTimeout),
      .cycle_count (bCycleCount),
      .store_count (bStoreCount),
      .final_pc    (bFinalPc)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Advance one clock; outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1; start = 1'b0; mem_write = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   // Start a run on A and drive it to completion. Hold cycles carry a stray
   // (100,7) store that must be ignored. storeAt: 0 none, -1 every RUN cycle.
   // The pc driven on RUN cycle k is 0x1000 + 4*k.
   task automatic runOnce(input int storeAt, input logic [31:0] sAddr,
                          input logic [31:0] sData, input bit startInHold,
                          output int holdCycles, output int runCycles,
                          output logic [15:0] firstCount);
      holdCycles = 0; runCycles = 0; firstCount = 16'hFFFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         mem_write = 1'b0; start = 1'b0;
         if (aCoreReset === 1'b0) begin
            runCycles++;
            pc = 32'h1000 + 32'(4 * runCycles);
            if (runCycles == 1) firstCount = aCycleCount;
            if (storeAt < 0 || runCycles == storeAt) begin
               mem_write = 1'b1; data_addr = sAddr; write_data = sData;
            end
         end else begin
            holdCycles++;
            pc = 32'hDEAD0000;
            mem_write = 1'b1; data_addr = 32'd100; write_data = 32'd7;
            if (startInHold && holdCycles == 1) start = 1'b1;
         end
         tick();
         if (aDone === 1'b1) break;
      end
      mem_write = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; mem_write = 1'b1;
      data_addr = 32'd100; write_data = 32'd25; pc = 32'h0;
      tick(); tick();
      total++; if (aCoreReset !== 1'b1) begin bad++; $display("FAIL reset_core_reset got=%0b exp=1", aCoreReset); end
      total++; if ({aDone, aPass, aFail, aTimeout} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {aDone, aPass, aFail, aTimeout}); end
      total++; if (aCycleCount !== 16'd0 || aStoreCount !== 16'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", aCycleCount, aStoreCount); end
      total++; if (aFinalPc !== 32'd0) begin bad++; $display("FAIL reset_final_pc got=%h exp=0", aFinalPc); end
      total++; if (bCoreReset !== 1'b1 || bDone !== 1'b0 || bStoreCount !== 2'd0) begin bad++; $display("FAIL reset_b got=%b%b%0d exp=1 0 0", bCoreReset, bDone, bStoreCount); end
      reset = 1'b0; start = 1'b0; mem_write = 1'b0;
   endtask

   task automatic test_pass();
      int h, r; logic [15:0] f;
      doReset();
      // Idle cycle with a signature store that must not count.
      mem_write = 1'b1; data_addr = 32'd100; write_data = 32'd25;
      tick();
      mem_write = 1'b0;
      total++; if (aDone !== 1'b0 || aStoreCount !== 16'd0 || aCoreReset !== 1'b1) begin bad++; $display("FAIL idle_store got=done%0b sc%0d cr%0b exp=done0 sc0 cr1", aDone, aStoreCount, aCoreReset); end
      runOnce(5, 32'd100, 32'd25, 1'b0, h, r, f);
      total++; if (h !== 2) begin bad++; $display("FAIL pass_hold got=%0d exp=2", h); end
      total++; if (r !== 5) begin bad++; $display("FAIL pass_run_len got=%0d exp=5", r); end
      total++; if (f !== 16'd0) begin bad++; $display("FAIL pass_first_count got=%0d exp=0", f); end
      total++; if ({aDone, aPass, aFail, aTimeout} !== 4'b1100) begin bad++; $display("FAIL pass_flags got=%b exp=1100", {aDone, aPass, aFail, aTimeout}); end
      total++; if (aCycleCount !== 16'd5) begin bad++; $display("FAIL pass_cycle_count got=%0d exp=5", aCycleCount); end
      total++; if (aStoreCount !== 16'd1) begin bad++; $display("FAIL pass_store_count got=%0d exp=1", aStoreCount); end
      total++; if (aFinalPc !== 32'h1014) begin bad++; $display("FAIL pass_final_pc got=%h exp=1014", aFinalPc); end
      total++; if (aCoreReset !== 1'b1) begin bad++; $display("FAIL pass_core_reset got=%0b exp=1", aCoreReset); end
   endtask

   task automatic test_fail();
      int h, r; logic [15:0] f;
      doReset();
      runOnce(3, 32'd100, 32'd7, 1'b0, h, r, f);
      total++; if ({aDone, aPass, aFail, aTimeout} !== 4'b1010) begin bad++; $display("FAIL fail_flags got=%b exp=1010", {aDone, aPass, aFail, aTimeout}); end
      total++; if (aFinalPc !== 32'h100C) begin bad++; $display("FAIL fail_final_pc got=%h exp=100c", aFinalPc); end
      total++; if (aCycleCount !== 16'd3 || aStoreCount !== 16'd1) begin bad++; $display("FAIL fail_counts got=%0d/%0d exp=3/1", aCycleCount, aStoreCount); end
      // Terminal state holds everything; stores and pc changes are ignored.
      mem_write = 1'b1; data_addr = 32'd100; write_data = 32'd25; pc = 32'h5555;
      tick(); tick(); tick();
      mem_write = 1'b0;
      total++; if ({aDone, aPass, aFail, aTimeout} !== 4'b1010) begin bad++; $display("FAIL fail_hold_flags got=%b exp=1010", {aDone, aPass, aFail, aTimeout}); end
      total++; if (aCycleCount !== 16'd3 || aStoreCount !== 16'd1 || aFinalPc !== 32'h100C) begin bad++; $display("FAIL fail_hold_values got=%0d/%0d/%h exp=3/1/100c", aCycleCount, aStoreCount, aFinalPc); end
   endtask

   task automatic test_timeout();
      int h, r; logic [15:0] f;
      doReset();
      runOnce(0, 32'd0, 32'd0, 1'b0, h, r, f);
      total++; if (r !== 16) begin bad++; $display("FAIL timeout_run_len got=%0d exp=16", r); end
      total++; if ({aDone, aPass, aFail, aTimeout} !== 4'b1001) begin bad++; $display("FAIL timeout_flags got=%b exp=1001", {aDone, aPass, aFail, aTimeout}); end
      total++; if (aCycleCount !== 16'd16 || aStoreCount !== 16'd0) begin bad++; $display("FAIL timeout_counts got=%0d/%0d exp=16/0", aCycleCount, aStoreCount); end
      total++; if (aFinalPc !== 32'h1040) begin bad++; $display("FAIL timeout_final_pc got=%h exp=1040", aFinalPc); end
   endtask

   // Restart straight out of TIMEOUT; a start pulse inside the hold is ignored
   // and the signature lands on the very last budgeted cycle.
   task automatic test_back_to_back();
      int h, r; logic [15:0] f;
      runOnce(16, 32'd100, 32'd25, 1'b1, h, r, f);
      total++; if (h !== 2) begin bad++; $display("FAIL b2b_hold got=%0d exp=2", h); end
      total++; if (f !== 16'd0) begin bad++; $display("FAIL b2b_first_count got=%0d exp=0", f); end
      total++; if ({aDone, aPass, aFail, aTimeout} !== 4'b1100) begin bad++; $display("FAIL last_cycle_flags got=%b exp=1100", {aDone, aPass, aFail, aTimeout}); end
      total++; if (aCycleCount !== 16'd16 || aStoreCount !== 16'd1) begin bad++; $display("FAIL last_cycle_counts got=%0d/%0d exp=16/1", aCycleCount, aStoreCount); end
      // Non-signature stores every cycle: counted, never terminating early.
      runOnce(-1, 32'd104, 32'd25, 1'b0, h, r, f);
      total++; if ({aDone, aTimeout} !== 2'b11 || aStoreCount !== 16'd16) begin bad++; $display("FAIL other_addr got=done%0b to%0b sc%0d exp=1 1 16", aDone, aTimeout, aStoreCount); end
   endtask

   task automatic test_reset_mid_run();
      int h, r; logic [15:0] f;
      doReset();
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 10 && aCoreReset !== 1'b0; i++) tick();
      total++; if (aCoreReset !== 1'b0) begin bad++; $display("FAIL midrun_enter got=%0b exp=0", aCoreReset); end
      tick(); tick(); tick();
      start = 1'b1; tick(); start = 1'b0;
      total++; if (aCoreReset !== 1'b0 || aCycleCount !== 16'd4) begin bad++; $display("FAIL start_in_run got=cr%0b cc%0d exp=cr0 cc4", aCoreReset, aCycleCount); end
      reset = 1'b1; tick(); reset = 1'b0;
      total++; if (aCoreReset !== 1'b1 || {aDone, aPass, aFail, aTimeout} !== 4'b0000) begin bad++; $display("FAIL midrun_reset_flags got=%b%b exp=1 0000", aCoreReset, {aDone, aPass, aFail, aTimeout}); end
      total++; if (aCycleCount !== 16'd0 || aStoreCount !== 16'd0 || aFinalPc !== 32'd0) begin bad++; $display("FAIL midrun_reset_values got=%0d/%0d/%h exp=0/0/0", aCycleCount, aStoreCount, aFinalPc); end
      runOnce(0, 32'd0, 32'd0, 1'b0, h, r, f);
      total++; if (h !== 2 || f !== 16'd0 || r !== 16) begin bad++; $display("FAIL midrun_fresh got=h%0d f%0d r%0d exp=h2 f0 r16", h, f, r); end
      // Reset during the hold, with start also high, lands in IDLE for good.
      start = 1'b1; tick(); start = 1'b0;
      reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
      tick(); tick(); tick(); tick();
      total++; if (aCoreReset !== 1'b1 || aDone !== 1'b0 || aCycleCount !== 16'd0) begin bad++; $display("FAIL midhold_reset got=cr%0b d%0b cc%0d exp=cr1 d0 cc0", aCoreReset, aDone, aCycleCount); end
   endtask

   task automatic test_saturate();
      doReset();
      start = 1'b1; tick(); start = 1'b0;
      mem_write = 1'b1; data_addr = 32'd104; write_data = 32'd0; pc = 32'hABC0;
      for (int i = 0; i < 7; i++) tick();
      mem_write = 1'b0;
      total++; if ({bDone, bPass, bFail, bTimeout} !== 4'b1001) begin bad++; $display("FAIL sat_flags got=%b exp=1001", {bDone, bPass, bFail, bTimeout}); end
      total++; if (bStoreCount !== 2'd3) begin bad++; $display("FAIL sat_store_count got=%0d exp=3", bStoreCount); end
      total++; if (bCycleCount !== 2'd3 || bFinalPc !== 32'hABC0) begin bad++; $display("FAIL sat_cycle_pc got=%0d/%h exp=3/abc0", bCycleCount, bFinalPc); end
      start = 1'b1; tick(); start = 1'b0;
      total++; if (bDone !== 1'b0 || bTimeout !== 1'b0 || bCoreReset !== 1'b1) begin bad++; $display("FAIL restart_flags got=d%0b to%0b cr%0b exp=d0 to0 cr1", bDone, bTimeout, bCoreReset); end
      total++; if (bCycleCount !== 2'd0 || bStoreCount !== 2'd0 || bFinalPc !== 32'd0) begin bad++; $display("FAIL restart_values got=%0d/%0d/%h exp=0/0/0", bCycleCount, bStoreCount, bFinalPc); end
      tick(); tick();
      total++; if (bCoreReset !== 1'b0 || bCycleCount !== 2'd0) begin bad++; $display("FAIL restart_run got=cr%0b cc%0d exp=cr0 cc0", bCoreReset, bCycleCount); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mem_write = 1'b0;
      data_addr = '0; write_data = '0; pc = '0;
      test_reset();
      test_pass();
      test_fail();
      test_timeout();
      test_back_to_back();
      test_reset_mid_run();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
